// File: rtl/mano_pkg.sv
// +---------------------------------------------------------------------------+
// | mano_pkg : shared constants and responder FSM encoding for Mano CPU       |
// | Rev 1.0                                                                   |
// +---------------------------------------------------------------------------+
`default_nettype none

package mano_pkg;
  localparam int DEF_DATA_W = 8;
  localparam int DEF_ADDR_W = 8;
  localparam int DEF_DEPTH  = 9;

  typedef logic [1:0] state_t;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;
endpackage

`default_nettype wire

// File: rtl/mano_ram_array.sv
// +---------------------------------------------------------------------------+
// | mano_ram_array : DEPTH x DATA_W word array, one write port, async read    |
// | Rev 1.0                                                                   |
// +---------------------------------------------------------------------------+
`default_nettype none

module mano_ram_array #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 9
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [DATA_W-1:0] o_rdata
);
  localparam int              C_IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] C_DEPTH = (ADDR_W + 1)'(DEPTH);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic              w_wr_in_range;
  logic              w_rd_in_range;

  // Addresses past the implemented words never touch the array.
  assign w_wr_in_range = ({1'b0, i_waddr} < C_DEPTH);
  assign w_rd_in_range = ({1'b0, i_raddr} < C_DEPTH);

  always_ff @(posedge clk) begin
    if (i_we && w_wr_in_range) begin
      r_mem[i_waddr[C_IDX_W-1:0]] <= i_wdata;
    end
  end

  assign o_rdata = w_rd_in_range ? r_mem[i_raddr[C_IDX_W-1:0]] : '0;
endmodule

`default_nettype wire

// File: rtl/mano_mem_responder.sv
// +---------------------------------------------------------------------------+
// | mano_mem_responder : req/ack memory responder with wait states + loader   |
// | Rev 1.0                                                                   |
// +---------------------------------------------------------------------------+
`default_nettype none

module mano_mem_responder
  import mano_pkg::*;
#(
  parameter int DATA_W      = DEF_DATA_W,
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int DEPTH       = DEF_DEPTH,
  parameter int WAIT_STATES = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_req,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  output logic              o_ack,
  output logic [DATA_W-1:0] o_rdata,
  output logic              o_busy,
  output logic              o_err,
  input  logic              i_ld_valid,
  input  logic [DATA_W-1:0] i_ld_data,
  output logic              o_ld_ready,
  output logic              o_ld_done
);
  localparam logic [ADDR_W:0]   C_DEPTH     = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0] C_LAST      = ADDR_W'(DEPTH - 1);
  localparam logic [3:0]        C_WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  state_t            r_state;
  logic [3:0]        r_cnt;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic              r_oor;
  logic [DATA_W-1:0] r_rdata;
  logic [ADDR_W-1:0] r_ptr;
  logic              r_ld_done;

  logic              w_capture;
  logic              w_ld_ready;
  logic              w_ld_accept;
  logic              w_in_oor;
  logic              w_to_resp;
  logic              w_rd_we;
  logic              w_rd_oor;
  logic [ADDR_W-1:0] w_raddr;
  logic              w_cpu_commit;
  logic              w_mem_we;
  logic [ADDR_W-1:0] w_mem_waddr;
  logic [DATA_W-1:0] w_mem_wdata;
  logic [DATA_W-1:0] w_mem_rdata;

  assign w_capture   = (r_state == S_IDLE) && i_req;
  assign w_ld_ready  = (r_state == S_IDLE) && !i_req && !reset;
  assign w_ld_accept = i_ld_valid && w_ld_ready;
  assign w_in_oor    = ({1'b0, i_addr} >= C_DEPTH);
  assign w_to_resp   = (w_capture && (WAIT_STATES == 0)) ||
                       ((r_state == S_WAIT) && (r_cnt == 4'd0));

  // With zero wait states the read happens at the capture edge, so it must use the live inputs.
  assign w_rd_we  = (r_state == S_IDLE) ? i_we     : r_we;
  assign w_rd_oor = (r_state == S_IDLE) ? w_in_oor : r_oor;
  assign w_raddr  = (r_state == S_IDLE) ? i_addr   : r_addr;

  // Requests and loads are mutually exclusive, so the write port never sees both.
  assign w_cpu_commit = (r_state == S_RESP) && r_we && !r_oor && !reset;
  assign w_mem_we     = w_cpu_commit || w_ld_accept;
  assign w_mem_waddr  = w_cpu_commit ? r_addr  : r_ptr;
  assign w_mem_wdata  = w_cpu_commit ? r_wdata : i_ld_data;

  mano_ram_array #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_ram (
    .clk     (clk),
    .i_we    (w_mem_we),
    .i_waddr (w_mem_waddr),
    .i_wdata (w_mem_wdata),
    .i_raddr (w_raddr),
    .o_rdata (w_mem_rdata)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_cnt     <= 4'd0;
      r_we      <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_oor     <= 1'b0;
      r_rdata   <= '0;
      r_ptr     <= '0;
      r_ld_done <= 1'b0;
    end else begin
      r_ld_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_req) begin
            r_we    <= i_we;
            r_addr  <= i_addr;
            r_wdata <= i_wdata;
            r_oor   <= w_in_oor;
            if (WAIT_STATES > 0) begin
              r_state <= S_WAIT;
              r_cnt   <= C_WAIT_LOAD;
            end else begin
              r_state <= S_RESP;
            end
          end
        end
        S_WAIT: begin
          if (r_cnt == 4'd0) begin
            r_state <= S_RESP;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        S_RESP:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase

      if (w_to_resp && !w_rd_we) begin
        r_rdata <= w_rd_oor ? '0 : w_mem_rdata;
      end

      if (w_ld_accept) begin
        if (r_ptr == C_LAST) begin
          r_ptr     <= '0;
          r_ld_done <= 1'b1;
        end else begin
          r_ptr <= r_ptr + 1'b1;
        end
      end
    end
  end

  assign o_ack      = (r_state == S_RESP);
  assign o_busy     = (r_state != S_IDLE);
  assign o_err      = (r_state == S_RESP) && r_oor;
  assign o_rdata    = r_rdata;
  assign o_ld_ready = w_ld_ready;
  assign o_ld_done  = r_ld_done;
endmodule

`default_nettype wire

// File: tb/tb_mano_mem_responder.sv
// +---------------------------------------------------------------------------+
// | tb_mano_mem_responder : scenario + randomized bench against a word model  |
// | Rev 1.0                                                                   |
// +---------------------------------------------------------------------------+
`default_nettype none

module tb_mano_mem_responder;
  localparam int DW    = 8;
  localparam int AW    = 8;
  localparam int DEPTH = 9;
  localparam int WS    = 1;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          req = 1'b0;
  logic          we = 1'b0;
  logic [AW-1:0] addr = '0;
  logic [DW-1:0] wdata = '0;
  logic          ld_valid = 1'b0;
  logic [DW-1:0] ld_data = '0;
  logic          ack, busy, err, ld_ready, ld_done;
  logic [DW-1:0] rdata;

  int n_cmp = 0;
  int n_bad = 0;

  logic [DW-1:0] m_mem [DEPTH];
  int            m_ptr = 0;
  logic [DW-1:0] m_rdata = '0;

  mano_mem_responder #(
    .DATA_W (DW), .ADDR_W (AW), .DEPTH (DEPTH), .WAIT_STATES (WS)
  ) dut (
    .clk (clk), .reset (reset), .i_req (req), .i_we (we), .i_addr (addr),
    .i_wdata (wdata), .o_ack (ack), .o_rdata (rdata), .o_busy (busy), .o_err (err),
    .i_ld_valid (ld_valid), .i_ld_data (ld_data), .o_ld_ready (ld_ready), .o_ld_done (ld_done)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One loader byte: expects acceptance this edge and ld_done exactly when the last word is filled.
  task automatic load_byte(input logic [DW-1:0] d);
    logic exp_done;
    req = 1'b0; ld_valid = 1'b1; ld_data = d;
    #1;
    n_cmp++;
    if (ld_ready !== 1'b1) begin
      n_bad++; $display("FAIL ld_ready_idle: got %b want 1", ld_ready);
    end
    tick();
    m_mem[m_ptr] = d;
    exp_done = (m_ptr == DEPTH - 1);
    m_ptr = exp_done ? 0 : m_ptr + 1;
    ld_valid = 1'b0;
    n_cmp++;
    if (ld_done !== exp_done) begin
      n_bad++; $display("FAIL ld_done: got %b want %b (ptr now %0d)", ld_done, exp_done, m_ptr);
    end
  endtask

  // One CPU access; inputs are scrambled right after capture to prove they are ignored.
  task automatic access(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    int k;
    logic oor;
    logic [DW-1:0] exp_rd;
    ld_valid = 1'b0; req = 1'b1; we = w; addr = a; wdata = d;
    tick();
    req = 1'b0; we = ~w; addr = AW'($urandom); wdata = DW'($urandom);
    oor = (int'(a) >= DEPTH);
    k = 0;
    while (ack !== 1'b1 && k < 40) begin
      n_cmp++;
      if (busy !== 1'b1) begin
        n_bad++; $display("FAIL busy_wait: got %b want 1 (addr %0d)", busy, a);
      end
      tick();
      k++;
    end
    n_cmp++;
    if (k !== WS) begin
      n_bad++; $display("FAIL ack_latency: got %0d extra cycles want %0d (addr %0d)", k, WS, a);
    end
    exp_rd = w ? m_rdata : (oor ? '0 : m_mem[a]);
    m_rdata = exp_rd;
    n_cmp++;
    if (busy !== 1'b1 || err !== oor) begin
      n_bad++; $display("FAIL ack_flags: got busy=%b err=%b want busy=1 err=%b (addr %0d)", busy, err, oor, a);
    end
    n_cmp++;
    if (rdata !== exp_rd) begin
      n_bad++; $display("FAIL rdata: got %h want %h (we=%b addr %0d)", rdata, exp_rd, w, a);
    end
    tick();
    if (w && !oor) m_mem[a] = d;
    n_cmp++;
    if (ack !== 1'b0 || busy !== 1'b0 || err !== 1'b0) begin
      n_bad++; $display("FAIL post_ack: got ack=%b busy=%b err=%b want 0/0/0", ack, busy, err);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; req = 1'b0; ld_valid = 1'b0;
    tick(); tick();
    n_cmp++;
    if ({ack, busy, err, ld_done, ld_ready} !== 5'b0 || rdata !== '0) begin
      n_bad++; $display("FAIL reset_outputs: got ack=%b busy=%b err=%b done=%b rdy=%b rdata=%h want all 0",
                        ack, busy, err, ld_done, ld_ready, rdata);
    end
    reset = 1'b0; m_ptr = 0; m_rdata = '0;
    #1;
    n_cmp++;
    if (ld_ready !== 1'b1) begin
      n_bad++; $display("FAIL ready_after_reset: got %b want 1", ld_ready);
    end
  endtask

  task automatic test_load();
    for (int i = 0; i < DEPTH; i++) load_byte(DW'(8'h10 + i));
    tick();
    n_cmp++;
    if (ld_done !== 1'b0 || m_ptr !== 0) begin
      n_bad++; $display("FAIL ld_done_pulse: got done=%b ptr=%0d want 0/0", ld_done, m_ptr);
    end
  endtask

  task automatic test_read();
    access(1'b0, 8'd3, 8'h00);
    n_cmp++;
    if (rdata !== 8'h13) begin
      n_bad++; $display("FAIL read3_value: got %h want 13", rdata);
    end
  endtask

  task automatic test_write_read();
    access(1'b1, 8'd5, 8'hA5);
    access(1'b0, 8'd5, 8'h00);
    n_cmp++;
    if (rdata !== 8'hA5) begin
      n_bad++; $display("FAIL write_readback: got %h want a5", rdata);
    end
    access(1'b0, 8'd4, 8'h00);
    n_cmp++;
    if (rdata !== 8'h14) begin
      n_bad++; $display("FAIL neighbour4: got %h want 14", rdata);
    end
    access(1'b0, 8'd6, 8'h00);
    n_cmp++;
    if (rdata !== 8'h16) begin
      n_bad++; $display("FAIL neighbour6: got %h want 16", rdata);
    end
  endtask

  task automatic test_out_of_range();
    access(1'b0, 8'd9, 8'h00);
    access(1'b1, 8'd12, 8'hFF);
    for (int i = 0; i < DEPTH; i++) access(1'b0, AW'(i), 8'h00);
  endtask

  task automatic test_priority();
    int slot;
    logic [DW-1:0] exp_rd;
    slot = m_ptr;
    exp_rd = m_mem[1];
    req = 1'b1; we = 1'b0; addr = 8'd1; ld_valid = 1'b1; ld_data = 8'hC3;
    #1;
    n_cmp++;
    if (ld_ready !== 1'b0) begin
      n_bad++; $display("FAIL prio_ready: got %b want 0", ld_ready);
    end
    tick();
    req = 1'b0;
    for (int k = 0; k < 40 && ack !== 1'b1; k++) tick();
    n_cmp++;
    if (ack !== 1'b1 || rdata !== exp_rd || ld_ready !== 1'b0) begin
      n_bad++; $display("FAIL prio_served: got ack=%b rdata=%h rdy=%b want 1/%h/0", ack, rdata, ld_ready, exp_rd);
    end
    m_rdata = exp_rd;
    tick();
    n_cmp++;
    if (ld_ready !== 1'b1 || m_ptr !== slot) begin
      n_bad++; $display("FAIL prio_ready_after: got %b want 1", ld_ready);
    end
    tick();
    m_mem[m_ptr] = 8'hC3;
    m_ptr = (m_ptr == DEPTH - 1) ? 0 : m_ptr + 1;
    ld_valid = 1'b0;
    access(1'b0, AW'(slot), 8'h00);
  endtask

  task automatic test_reset_abort();
    req = 1'b1; we = 1'b1; addr = 8'd2; wdata = 8'h77;
    tick();
    req = 1'b0;
    n_cmp++;
    if (busy !== 1'b1) begin
      n_bad++; $display("FAIL abort_busy: got %b want 1", busy);
    end
    reset = 1'b1;
    tick();
    m_ptr = 0; m_rdata = '0;
    n_cmp++;
    if ({ack, busy, err, ld_done, ld_ready} !== 5'b0 || rdata !== '0) begin
      n_bad++; $display("FAIL abort_outputs: got ack=%b busy=%b err=%b done=%b rdy=%b rdata=%h want all 0",
                        ack, busy, err, ld_done, ld_ready, rdata);
    end
    reset = 1'b0;
    tick(); tick();
    n_cmp++;
    if (ack !== 1'b0 || busy !== 1'b0) begin
      n_bad++; $display("FAIL abort_no_ack: got ack=%b busy=%b want 0/0", ack, busy);
    end
    access(1'b0, 8'd2, 8'h00);
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] exp_a, exp_b;
    exp_a = m_mem[7];
    exp_b = m_mem[0];
    req = 1'b1; we = 1'b0; addr = 8'd7;
    tick();
    addr = 8'd0;
    repeat (WS) tick();
    n_cmp++;
    if (ack !== 1'b1 || rdata !== exp_a) begin
      n_bad++; $display("FAIL b2b_first: got ack=%b rdata=%h want 1/%h", ack, rdata, exp_a);
    end
    tick();
    n_cmp++;
    if (ack !== 1'b0 || busy !== 1'b0) begin
      n_bad++; $display("FAIL b2b_gap: got ack=%b busy=%b want 0/0", ack, busy);
    end
    tick();
    req = 1'b0;
    repeat (WS) tick();
    n_cmp++;
    if (ack !== 1'b1 || rdata !== exp_b) begin
      n_bad++; $display("FAIL b2b_second: got ack=%b rdata=%h want 1/%h", ack, rdata, exp_b);
    end
    m_rdata = exp_b;
    tick();
  endtask

  task automatic test_random();
    for (int n = 0; n < 80; n++) begin
      case ($urandom_range(0, 2))
        0:       access(1'b0, AW'($urandom_range(0, 15)), 8'h00);
        1:       access(1'b1, AW'($urandom_range(0, 15)), DW'($urandom));
        default: load_byte(DW'($urandom));
      endcase
    end
    for (int i = 0; i < DEPTH; i++) access(1'b0, AW'(i), 8'h00);
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) m_mem[i] = 'x;
    test_reset();
    test_load();
    test_read();
    test_write_read();
    test_out_of_range();
    test_priority();
    test_reset_abort();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

`default_nettype wire
